serdes_align_ctrl: RTL and testbench

// - Sequences SERDES word alignment for one sensor lane, in the px_clk domain.
// - Flow: start the lock-mask generator, capture its 12 x 32-bit mask writes, scan them
//   for the widest eye (longest run of locked delay taps), then apply centre delay + slips.
// - Sits between the sensor control register block and the lock-mask generator / IDELAY / ISERDES bitslip.

---
 rtl/serdes_align_pkg.sv | 25 ++
 rtl/serdes_align_ctrl_eye_scan.sv | 49 ++++
 rtl/serdes_align_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_serdes_align_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serdes_align_pkg.sv
// Shared types for the SERDES word-alignment controller.
// Build option SERDES_ALIGN_RETRY_EN is consumed by serdes_align_ctrl.
package serdes_align_pkg;

   localparam int NUM_TAP   = 32;
   localparam int MAX_RETRY = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_KICK,
      S_WAIT_GEN,
      S_SCAN,
      S_DECIDE,
      S_LOAD,
      S_SLIP,
      S_DONE
   } align_fsm_e;

   typedef struct packed {
      logic [5:0] width;
      logic [3:0] slip;
      logic [5:0] centre;
   } eye_s;

endpackage

// File: rtl/serdes_align_ctrl_eye_scan.sv
// Bit-serial longest-run finder: one tap per cycle, reports each closed run.
// A run closes on a 0 bit or on the last tap of an entry.
module serdes_eye_scan
   import serdes_align_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       vld_i,
   input  logic       bit_i,
   input  logic [4:0] tap_i,
   output logic       close_o,
   output logic [4:0] run_start_o,
   output logic [5:0] run_w_o
);

   logic [5:0] run_w_q, run_w_d;
   logic [4:0] run_start_q, run_start_d;
   logic       last;

   assign last = (tap_i == 5'(NUM_TAP - 1));

   always_comb begin
      run_w_d     = run_w_q;
      run_start_d = run_start_q;
      close_o     = 1'b0;
      run_w_o     = bit_i ? run_w_q + 6'd1 : run_w_q;
      run_start_o = (bit_i && run_w_q == '0) ? tap_i : run_start_q;
      if (vld_i) begin
         if (!bit_i || last) begin
            close_o = 1'b1;
            run_w_d = '0;
         end else begin
            run_w_d     = run_w_o;
            run_start_d = run_start_o;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         run_w_q     <= '0;
         run_start_q <= '0;
      end else begin
         run_w_q     <= run_w_d;
         run_start_q <= run_start_d;
      end
   end

endmodule

// File: rtl/serdes_align_ctrl.sv
// SERDES word-alignment sequencer: capture lock masks, find widest eye, apply delay+slips.
// Optional `define SERDES_ALIGN_RETRY_EN retries failed attempts up to MAX_RETRY times.
module serdes_align_ctrl
   import serdes_align_pkg::*;
#(
   parameter int    NUM_SLIP    = 12,
   parameter int    MIN_EYE     = 4,
   parameter int    SLIP_GAP    = 4,
   parameter int    GEN_TIMEOUT = 2**24,
   parameter string DEBUG       = "FALSE"
) (
   input  logic        px_clk,
   input  logic        px_reset,
   input  logic        align_req,
   output logic        gen_start,
   input  logic        gen_done,
   input  logic [31:0] mask_din,
   input  logic [3:0]  mask_waddr,
   input  logic        mask_we,
   output logic [7:0]  delay_num,
   output logic        delay_ld,
   output logic        bitslip,
   output logic [5:0]  eye_width,
   output logic        align_done,
   output logic        align_ok
);

   localparam int TW = $clog2(GEN_TIMEOUT);
   localparam int GW = $clog2(SLIP_GAP + 1);

   align_fsm_e       state_q, state_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [3:0]       nslip_q, nslip_d;
   logic [3:0]       scan_s_q, scan_s_d;
   logic [4:0]       scan_t_q, scan_t_d;
   eye_s             best_q, best_d;
   logic [7:0]       dnum_q, dnum_d;
   logic [5:0]       ew_q, ew_d;
   logic             ok_q, ok_d;
   logic             clr_mask, fail;
   logic [NUM_TAP-1:0] mask_q [NUM_SLIP];

   logic       tap_bit, run_close;
   logic [4:0] run_start;
   logic [5:0] run_w;

`ifdef SERDES_ALIGN_RETRY_EN
   logic [1:0] retry_q, retry_d;
`endif

   assign tap_bit = mask_q[scan_s_q][scan_t_q];

   serdes_eye_scan u_scan (
      .clk_i       (px_clk),
      .rst_i       (px_reset),
      .vld_i       (state_q == S_SCAN),
      .bit_i       (tap_bit),
      .tap_i       (scan_t_q),
      .close_o     (run_close),
      .run_start_o (run_start),
      .run_w_o     (run_w)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      nslip_d    = nslip_q;
      scan_s_d   = scan_s_q;
      scan_t_d   = scan_t_q;
      best_d     = best_q;
      dnum_d     = dnum_q;
      ew_d       = ew_q;
      ok_d       = ok_q;
      clr_mask   = 1'b0;
      fail       = 1'b0;
      gen_start  = 1'b0;
      delay_ld   = 1'b0;
      bitslip    = 1'b0;
      align_done = 1'b0;
`ifdef SERDES_ALIGN_RETRY_EN
      retry_d    = retry_q;
`endif
      unique case (state_q)
         S_IDLE: if (align_req) begin
            state_d  = S_KICK;
            clr_mask = 1'b1;
            best_d   = '0;
            ok_d     = 1'b0;
`ifdef SERDES_ALIGN_RETRY_EN
            retry_d  = '0;
`endif
         end
         S_KICK: begin
            gen_start = 1'b1;
            cnt_d     = '0;
            state_d   = S_WAIT_GEN;
         end
         S_WAIT_GEN: begin
            if (gen_done) begin
               state_d  = S_SCAN;
               scan_s_d = '0;
               scan_t_d = '0;
            end else if (cnt_q == TW'(GEN_TIMEOUT - 1)) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SCAN: begin
            scan_t_d = scan_t_q + 5'd1;
            if (scan_t_q == 5'(NUM_TAP - 1)) begin
               scan_s_d = scan_s_q + 4'd1;
               if (scan_s_q == 4'(NUM_SLIP - 1)) state_d = S_DECIDE;
            end
            // strictly wider only: earlier slip/tap wins ties
            if (run_close && run_w > best_q.width) begin
               best_d.width  = run_w;
               best_d.slip   = scan_s_q;
               best_d.centre = {1'b0, run_start} + {1'b0, run_w[5:1]};
            end
         end
         S_DECIDE: begin
            if (best_q.width >= 6'(MIN_EYE)) begin
               state_d = S_LOAD;
               dnum_d  = {2'b00, best_q.centre};
            end else begin
               fail = 1'b1;
            end
         end
         S_LOAD: begin
            delay_ld = 1'b1;
            gap_d    = GW'(1);
            nslip_d  = '0;
            if (best_q.slip == '0) begin
               state_d = S_DONE;
               ok_d    = 1'b1;
               ew_d    = best_q.width;
            end else begin
               state_d = S_SLIP;
            end
         end
         S_SLIP: begin
            if (gap_q == GW'(SLIP_GAP)) begin
               bitslip = 1'b1;
               gap_d   = GW'(1);
               nslip_d = nslip_q + 4'd1;
               if (nslip_q + 4'd1 == best_q.slip) begin
                  state_d = S_DONE;
                  ok_d    = 1'b1;
                  ew_d    = best_q.width;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_DONE: begin
            align_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef SERDES_ALIGN_RETRY_EN
      if (fail && retry_q != 2'(MAX_RETRY)) begin
         retry_d  = retry_q + 2'd1;
         state_d  = S_KICK;
         clr_mask = 1'b1;
         best_d   = '0;
      end else if (fail) begin
         state_d = S_DONE;
         ok_d    = 1'b0;
         ew_d    = best_q.width;
      end
`else
      if (fail) begin
         state_d = S_DONE;
         ok_d    = 1'b0;
         ew_d    = best_q.width;
      end
`endif
   end

   always_ff @(posedge px_clk or posedge px_reset) begin
      if (px_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         gap_q    <= '0;
         nslip_q  <= '0;
         scan_s_q <= '0;
         scan_t_q <= '0;
         best_q   <= '0;
         dnum_q   <= '0;
         ew_q     <= '0;
         ok_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         nslip_q  <= nslip_d;
         scan_s_q <= scan_s_d;
         scan_t_q <= scan_t_d;
         best_q   <= best_d;
         dnum_q   <= dnum_d;
         ew_q     <= ew_d;
         ok_q     <= ok_d;
      end
   end

`ifdef SERDES_ALIGN_RETRY_EN
   always_ff @(posedge px_clk or posedge px_reset) begin
      if (px_reset) retry_q <= '0;
      else          retry_q <= retry_d;
   end
`endif

   always_ff @(posedge px_clk or posedge px_reset) begin
      if (px_reset) begin
         for (int i = 0; i < NUM_SLIP; i++) mask_q[i] <= '0;
      end else if (clr_mask) begin
         for (int i = 0; i < NUM_SLIP; i++) mask_q[i] <= '0;
      end else if (mask_we && state_q != S_IDLE) begin
         for (int i = 0; i < NUM_SLIP; i++)
            if (mask_waddr == 4'(i)) mask_q[i] <= mask_din;
      end
   end

   generate
      if (DEBUG == "TRUE") begin : g_debug
         align_fsm_e dbg_state_q;
         always_ff @(posedge px_clk or posedge px_reset) begin
            if (px_reset) dbg_state_q <= S_IDLE;
            else          dbg_state_q <= state_q;
         end
      end
   endgenerate

   assign delay_num = dnum_q;
   assign eye_width = ew_q;
   assign align_ok  = ok_q;

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Directed bench for serdes_align_ctrl (GEN_TIMEOUT shortened to 64).
// Responds as the lock-mask generator and checks pulses, timing and results.
module tb_serdes_align_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        align_req = 1'b0;
   logic        gen_done = 1'b0;
   logic        mask_we = 1'b0;
   logic [31:0] mask_din = '0;
   logic [3:0]  mask_waddr = '0;
   logic        gen_start, delay_ld, bitslip, align_done, align_ok;
   logic [7:0]  delay_num;
   logic [5:0]  eye_width;

`ifdef SERDES_ALIGN_RETRY_EN
   localparam int NGEN = 4;
`else
   localparam int NGEN = 1;
`endif

   always #5 clk = ~clk;

   serdes_align_ctrl #(
      .NUM_SLIP(12), .MIN_EYE(4), .SLIP_GAP(4), .GEN_TIMEOUT(64), .DEBUG("FALSE")
   ) dut (
      .px_clk(clk), .px_reset(rst), .align_req(align_req),
      .gen_start(gen_start), .gen_done(gen_done),
      .mask_din(mask_din), .mask_waddr(mask_waddr), .mask_we(mask_we),
      .delay_num(delay_num), .delay_ld(delay_ld), .bitslip(bitslip),
      .eye_width(eye_width), .align_done(align_done), .align_ok(align_ok)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_gs = 0, n_ld = 0, n_bs = 0, n_done = 0, gap_err = 0;
   int t_ev = 0, t_ld = 0, t_done = 0;
   always @(negedge clk) begin
      if (gen_start) n_gs++;
      if (delay_ld) begin n_ld++; t_ld = cyc; t_ev = cyc; end
      if (bitslip) begin
         if (cyc - t_ev != 4) gap_err++;
         t_ev = cyc;
         n_bs++;
      end
      if (align_done) begin n_done++; t_done = cyc; end
   end

   int checks = 0, passes = 0, fails = 0;
   int b_gs, b_ld, b_bs, b_done, b_gap, t_gs;
   logic [31:0] mv [12];
   logic        s_ok;
   logic [5:0]  s_ew;
   logic [7:0]  s_dn;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_gs = n_gs; b_ld = n_ld; b_bs = n_bs; b_done = n_done; b_gap = gap_err;
   endtask

   task automatic start();
      @(negedge clk) align_req = 1'b1;
      @(negedge clk) align_req = 1'b0;
   endtask

   task automatic wait_gs();
      int k = 0;
      while (gen_start !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
      chk("gen_start_seen", 32'(gen_start), 1);
      t_gs = cyc;
   endtask

   // entry 12 is out of range and must be dropped; last write shares the cycle with gen_done
   task automatic gen_respond();
      wait_gs();
      @(negedge clk);
      mask_we = 1'b1; mask_waddr = 4'd12; mask_din = 32'hFFFF_FFFF;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         mask_waddr = 4'(i); mask_din = mv[i]; gen_done = (i == 11);
      end
      @(negedge clk);
      mask_we = 1'b0; gen_done = 1'b0; mask_din = '0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (align_done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
      chk("align_done_seen", 32'(align_done), 1);
      s_ok = align_ok; s_ew = eye_width; s_dn = delay_num;
      @(negedge clk);
   endtask

   task automatic clr_mv();
      for (int i = 0; i < 12; i++) mv[i] = '0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_gen_start"}, 32'(gen_start), 0);
      chk({tag, "_delay_ld"}, 32'(delay_ld), 0);
      chk({tag, "_bitslip"}, 32'(bitslip), 0);
      chk({tag, "_align_done"}, 32'(align_done), 0);
      chk({tag, "_align_ok"}, 32'(align_ok), 0);
      chk({tag, "_delay_num"}, 32'(delay_num), 0);
      chk({tag, "_eye_width"}, 32'(eye_width), 0);
   endtask

   task automatic run_eye5(input string tag);
      snap();
      start();
      gen_respond();
      wait_done();
      chk({tag, "_ok"}, 32'(s_ok), 1);
      chk({tag, "_eye"}, 32'(s_ew), 8);
      chk({tag, "_dnum"}, 32'(s_dn), 12);
      chk({tag, "_slips"}, 32'(n_bs - b_bs), 5);
      chk({tag, "_gap"}, 32'(gap_err - b_gap), 0);
      chk({tag, "_ld"}, 32'(n_ld - b_ld), 1);
      chk({tag, "_done"}, 32'(n_done - b_done), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single eye on slip 5, taps 8..15
      clr_mv(); mv[5] = 32'h0000_FF00;
      run_eye5("eye5");
      chk("eye5_ok_level", 32'(align_ok), 1);

      // tie between slips 2 and 7; align_req while busy is ignored
      clr_mv(); mv[2] = 32'h0000_00F0; mv[7] = 32'h0000_00F0;
      snap();
      start();
      gen_respond();
      start();
      wait_done();
      chk("tie_ok", 32'(s_ok), 1);
      chk("tie_eye", 32'(s_ew), 4);
      chk("tie_dnum", 32'(s_dn), 6);
      chk("tie_slips", 32'(n_bs - b_bs), 2);
      chk("tie_gap", 32'(gap_err - b_gap), 0);
      chk("busy_req_ignored", 32'(n_gs - b_gs), 1);

      // full-width eye on slip 0: no slips, DONE straight after LOAD
      clr_mv(); mv[0] = 32'hFFFF_FFFF;
      snap();
      start();
      gen_respond();
      wait_done();
      chk("full_ok", 32'(s_ok), 1);
      chk("full_eye", 32'(s_ew), 32);
      chk("full_dnum", 32'(s_dn), 16);
      chk("full_slips", 32'(n_bs - b_bs), 0);
      chk("full_ld_to_done", 32'(t_done - t_ld), 1);

      // every eye 3 taps wide: fail
      for (int i = 0; i < 12; i++) mv[i] = 32'h0000_0007;
      snap();
      start();
      chk("req_clears_ok", 32'(align_ok), 0);
      for (int r = 0; r < NGEN; r++) gen_respond();
      wait_done();
      chk("narrow_ok", 32'(s_ok), 0);
      chk("narrow_eye", 32'(s_ew), 3);
      chk("narrow_ld", 32'(n_ld - b_ld), 0);
      chk("narrow_gen_starts", 32'(n_gs - b_gs), NGEN);
      chk("narrow_done", 32'(n_done - b_done), 1);

      // generator never finishes: timeout
      snap();
      start();
      wait_gs();
      wait_done();
      chk("tmo_ok", 32'(s_ok), 0);
      chk("tmo_eye", 32'(s_ew), 0);
      chk("tmo_latency", 32'(t_done - t_gs), 65 * NGEN);
      chk("tmo_gen_starts", 32'(n_gs - b_gs), NGEN);

      // reset after the second bitslip
      clr_mv(); mv[5] = 32'h0000_FF00;
      snap();
      start();
      gen_respond();
      begin
         int k = 0;
         while (n_bs - b_bs < 2 && k < 3000) begin @(negedge clk); k++; end
      end
      chk("abort_two_slips", 32'(n_bs - b_bs), 2);
      rst = 1'b1;
      #1;
      check_idle_outputs("abort");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_more_slips", 32'(n_bs - b_bs), 2);
      chk("abort_no_done", 32'(n_done - b_done), 0);

      run_eye5("rerun");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
